sram_pipe: RTL



---
 rtl/sram_pipe.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_pipe.sv
`default_nettype none
// sram_pipe rev 1.0: single-port SRAM behind a valid/ready request channel, fixed-latency
// read pipeline and credit-protected fall-through response buffer. Option: SRAM_PIPE_INIT_ZERO_EN.
module sram_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int USER_EN    = 0,
    parameter int NUM_WORDS  = 1024,
    parameter int READ_LAT   = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [$clog2(NUM_WORDS)-1:0]  req_addr_i,
    input  logic [DATA_WIDTH-1:0]         req_wdata_i,
    input  logic [(DATA_WIDTH+7)/8-1:0]   req_be_i,
    input  logic [USER_WIDTH-1:0]         req_wuser_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic [USER_WIDTH-1:0]         rsp_ruser_o,
    output logic                          init_done_o
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(BUF_DEPTH - 1);

    logic                  accept, rd_accept, wr_accept, pop, push, buf_pop, buf_empty;
    logic                  in_range;
    logic [CW-1:0]         credits, buf_count;
    logic [PW-1:0]         rd_ptr, wr_ptr;

    logic                  wr_en, wr_user_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data, wr_mask;
    logic [USER_WIDTH-1:0] wr_user;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [USER_WIDTH-1:0] rd_user;

    logic [READ_LAT-1:0]   pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [READ_LAT];
    logic [USER_WIDTH-1:0] pipe_user [READ_LAT];
    logic [DATA_WIDTH-1:0] buf_data  [BUF_DEPTH];
    logic [USER_WIDTH-1:0] buf_user  [BUF_DEPTH];

`ifdef SRAM_PIPE_INIT_ZERO_EN
    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    state_t        state, state_next;
    logic [AW-1:0] init_addr, init_addr_next;
    logic          init_wr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state     <= state_next;
            init_addr <= init_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        init_addr_next = init_addr;
        init_wr        = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr = 1'b1;
                if (init_addr == AW'(NUM_WORDS - 1)) state_next = ST_RUN;
                else                                 init_addr_next = init_addr + AW'(1);
            end
            default: ;
        endcase
    end

    assign init_done_o = (state == ST_RUN);
`else
    logic init_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) init_done_q <= 1'b0;
        else         init_done_q <= 1'b1;
    end

    assign init_done_o = init_done_q;
`endif

    generate
        if ((1 << AW) == NUM_WORDS) begin : g_range_full
            assign in_range = 1'b1;
        end else begin : g_range_cmp
            localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_WORDS - 1);
            assign in_range = (req_addr_i <= ADDR_LAST);
        end
    endgenerate

    // A pop in the same cycle frees its credit immediately, so BUF_DEPTH==READ_LAT sustains full rate.
    assign req_ready_o = init_done_o & ((credits < CREDIT_MAX) | pop);
    assign accept      = req_valid_i & req_ready_o;
    assign rd_accept   = accept & ~req_we_i;
    assign wr_accept   = accept & req_we_i;

    always_comb begin
        wr_en      = wr_accept & in_range;
        wr_addr    = req_addr_i;
        wr_data    = req_wdata_i;
        wr_user    = req_wuser_i;
        wr_user_en = |req_be_i;
        for (int i = 0; i < DATA_WIDTH; i++) wr_mask[i] = req_be_i[i/8];
`ifdef SRAM_PIPE_INIT_ZERO_EN
        if (init_wr) begin
            wr_en      = 1'b1;
            wr_addr    = init_addr;
            wr_data    = '0;
            wr_user    = '0;
            wr_user_en = 1'b1;
            wr_mask    = '1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end

    assign rd_word = in_range ? mem[req_addr_i] : '0;

    generate
        if (USER_EN != 0) begin : g_user
            logic [USER_WIDTH-1:0] umem [NUM_WORDS];
            always_ff @(posedge clk_i) begin
                if (wr_en && wr_user_en) umem[wr_addr] <= wr_user;
            end
            assign rd_user = in_range ? umem[req_addr_i] : '0;
        end else begin : g_no_user
            logic unused_user;
            assign unused_user = ^{wr_user, wr_user_en};
            assign rd_user     = '0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_data[i] <= '0;
                pipe_user[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= rd_word;
                pipe_user[0] <= rd_user;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                    pipe_user[i] <= pipe_user[i-1];
                end
            end
        end
    end

    // Pipeline output bypasses the buffer when it is empty and the consumer is ready.
    assign buf_empty   = (buf_count == '0);
    assign rsp_valid_o = ~buf_empty | pipe_valid[READ_LAT-1];
    assign rsp_rdata_o = buf_empty ? pipe_data[READ_LAT-1] : buf_data[rd_ptr];
    assign rsp_ruser_o = buf_empty ? pipe_user[READ_LAT-1] : buf_user[rd_ptr];
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign push        = pipe_valid[READ_LAT-1] & ~(buf_empty & rsp_ready_i);
    assign buf_pop     = pop & ~buf_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits   <= '0;
            buf_count <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_user[i] <= '0;
            end
        end else begin
            if (rd_accept && !pop)      credits <= credits + CW'(1);
            else if (!rd_accept && pop) credits <= credits - CW'(1);

            if (push && !buf_pop)      buf_count <= buf_count + CW'(1);
            else if (!push && buf_pop) buf_count <= buf_count - CW'(1);

            if (push) begin
                buf_data[wr_ptr] <= pipe_data[READ_LAT-1];
                buf_user[wr_ptr] <= pipe_user[READ_LAT-1];
                wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (buf_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        end
    end
endmodule
`default_nettype wire
